// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell shared by every step of the serial addition.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: latches operands on start, adds LSB-first through
// one full_adder over W cycles, then pulses done with the registered result.
//   state  | meaning
//   S_IDLE | waiting for start, last result held on sum_out/cout
//   S_RUN  | one operand bit pair consumed per cycle
//   S_DONE | one-cycle done pulse, start ignored
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         cout
);

    localparam int CNT_W = ($clog2(W) > 0) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     sum_out_q, sum_out_d;
    logic             cout_q, cout_d;
    logic             fs, fc;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fs),
        .cout (fc)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Shift-and-or form keeps the W=1 case free of empty slices.
                sum_sh_d = (sum_sh_q >> 1) | (W'(fs) << (W - 1));
                carry_d  = fc;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_out_d = sum_sh_d;
                    cout_d    = fc;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign sum_out = sum_out_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: per-cycle comparison of a W=8 and a W=1 instance
// against an operation-level model, plus directed literal cases.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       cin8   = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1     = '0;
    logic [0:0] b1     = '0;
    logic       cin1   = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder_ctrl #(.W(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a_in    (a8),
        .b_in    (b8),
        .cin     (cin8),
        .busy    (busy8),
        .done    (done8),
        .sum_out (sum8),
        .cout    (cout8)
    );

    serial_adder_ctrl #(.W(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .cin     (cin1),
        .busy    (busy1),
        .done    (done1),
        .sum_out (sum1),
        .cout    (cout1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int ops8    = 0;

    // Operation-level model: cycles left in the operation, done flag, result.
    typedef struct {
        int          left;
        bit          dn;
        logic [64:0] pend;
        logic [63:0] sum;
        logic        co;
    } mdl_t;

    mdl_t m8 = '{default: 0};
    mdl_t m1 = '{default: 0};

    function automatic mdl_t mstep(mdl_t m, int w, logic r, logic s,
                                   logic [63:0] a, logic [63:0] b, logic c);
        mdl_t n = m;
        logic [64:0] tot;
        tot = {1'b0, a} + {1'b0, b} + {64'd0, c};
        if (r) begin
            n.left = 0;
            n.dn   = 1'b0;
            n.pend = '0;
            n.sum  = '0;
            n.co   = 1'b0;
        end else if (m.dn) begin
            n.dn = 1'b0;
        end else if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.sum = m.pend[63:0] & ((64'd1 << w) - 64'd1);
                n.co  = m.pend[w];
                n.dn  = 1'b1;
            end
        end else if (s) begin
            n.pend = tot;
            n.left = w;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst && !m8.dn && m8.left == 0 && start8) ops8++;
        m8 = mstep(m8, 8, rst, start8, {56'd0, a8}, {56'd0, b8}, cin8);
        m1 = mstep(m1, 1, rst, start1, {63'd0, a1}, {63'd0, b1}, cin1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_w8", 64'({busy8, done8, cout8, sum8}),
                  64'({(m8.left > 0), m8.dn, m8.co, m8.sum[7:0]}));
            check("cyc_w1", 64'({busy1, done1, cout1, sum1}),
                  64'({(m1.left > 0), m1.dn, m1.co, m1.sum[0]}));
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a;
        b8 = b;
        cin8 = c;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input int maxc, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!done8 && lat < maxc) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done8) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done8: no done within %0d cycles", maxc);
        end
    endtask

    initial begin
        int lat, bc, nd, prev, base, cyc;

        repeat (2) @(negedge clk);
        check("rst_w8", 64'({busy8, done8, cout8, sum8}), 64'd0);
        check("rst_w1", 64'({busy1, done1, cout1, sum1}), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        go8(8'h0F, 8'h01, 1'b0);
        wait_done8(30, lat, bc);
        check("c1_lat", 64'(lat), 64'd9);
        check("c1_busy", 64'(bc), 64'd8);
        check("c1_sum", 64'(sum8), 64'h10);
        check("c1_cout", 64'(cout8), 64'd0);
        @(negedge clk);

        go8(8'hFF, 8'h01, 1'b0);
        wait_done8(30, lat, bc);
        check("c2a_sum", 64'(sum8), 64'h00);
        check("c2a_cout", 64'(cout8), 64'd1);
        @(negedge clk);
        go8(8'hFF, 8'hFF, 1'b1);
        wait_done8(30, lat, bc);
        check("c2b_sum", 64'(sum8), 64'hFF);
        check("c2b_cout", 64'(cout8), 64'd1);
        @(negedge clk);

        go8(8'h0F, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'h55;
        b8 = 8'h55;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(30, lat, bc);
        check("c3_sum", 64'(sum8), 64'h10);
        check("c3_cout", 64'(cout8), 64'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("c3_extra_done", 64'(nd), 64'd0);

        go8(8'hFF, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("c4_abort", 64'({busy8, done8, cout8, sum8}), 64'd0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("c4_no_done", 64'(nd), 64'd0);

        a8 = 8'h01;
        b8 = 8'h02;
        cin8 = 1'b0;
        start8 = 1'b1;
        nd = 0;
        prev = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done8) begin
                nd++;
                if (prev >= 0) check("c5_spacing", 64'(i - prev), 64'd10);
                check("c5_sum", 64'({cout8, sum8}), 64'h003);
                prev = i;
            end
        end
        start8 = 1'b0;
        check("c5_ndone_ge4", 64'(nd >= 4), 64'd1);
        repeat (12) @(negedge clk);

        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("c6_lat", 64'(lat), 64'd2);
        check("c6_res", 64'({cout1, sum1}), 64'h3);
        @(negedge clk);

        base = ops8;
        cyc = 0;
        while ((ops8 - base) < 1000 && cyc < 30000) begin
            rst    = ($urandom_range(0, 299) == 0);
            start8 = ($urandom_range(0, 3) != 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom_range(0, 1));
            start1 = 1'($urandom_range(0, 1));
            a1     = 1'($urandom);
            b1     = 1'($urandom);
            cin1   = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        check("rand_ops_done", 64'((ops8 - base) >= 1000), 64'd1);
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
